// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// the latched request record and the rejection rules.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_e;

    localparam logic [31:0] ZERO32 = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        size_e       size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_misaligned(size_e size, logic [31:0] addr);
        case (size)
            SZ_HALF: return addr[0];
            SZ_WORD: return addr[1:0] != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Illegal sizes are always rejected; misalignment only when trapping is on.
    function automatic logic is_rejected(size_e size, logic [31:0] addr, logic trap_en);
        return (size == SZ_ILL) || (trap_en && is_misaligned(size, addr));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response and memory-bus signals of the memory access unit.
// slave = the unit itself, master = the requester plus memory environment.
interface mem_access_if;

    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;

    modport slave (
        input  req, req_we, req_size, req_signed, req_addr, req_wdata, read_data,
        output busy, done, rdata, err, address, write_data, mem_read, mem_write
    );

    modport master (
        output req, req_we, req_size, req_signed, req_addr, req_wdata, read_data,
        input  busy, done, rdata, err, address, write_data, mem_read, mem_write
    );

endinterface

// File: rtl/mem_align.sv
// Combinational big-endian lane logic: sub-word load extraction from the top
// bytes of the memory word, and merge of store data into the fetched word.
module mem_align
    import mem_access_pkg::*;
(
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic ext_bit;
    assign ext_bit = sgn & mem_word[31];

    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves
        // them unassigned, which would otherwise infer a latch.
        load_data  = mem_word;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{ext_bit}}, mem_word[31:24]};
                store_data = {wdata[7:0], mem_word[23:0]};
            end
            SZ_HALF: begin
                load_data  = {{16{ext_bit}}, mem_word[31:16]};
                store_data = {wdata[15:0], mem_word[15:0]};
            end
            default: begin
                load_data  = mem_word;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a single-request port and a word memory.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with err.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        lat_q;
    size_e       req_size_e;

    logic        busy_q, done_q, err_q, err_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data, store_data;

    assign req_size_e = size_e'(bus.req_size);

    // The fetched word is merged on the fly, so write_data itself serves as
    // the merge register for sub-word stores.
    mem_align u_align (
        .size       (lat_q.size),
        .sgn        (lat_q.sgn),
        .mem_word   (bus.read_data),
        .wdata      (lat_q.wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = ZERO32;
        wdata_d = ZERO32;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (is_rejected(req_size_e, bus.req_addr, TRAP_EN)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (bus.req_we && req_size_e == SZ_WORD) begin
                        state_d = ST_WR;
                        wr_d    = 1'b1;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                    end else begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                        addr_d  = bus.req_addr;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == LAST_CNT) begin
                    if (lat_q.we) begin
                        state_d = ST_WR;
                        wr_d    = 1'b1;
                        addr_d  = lat_q.addr;
                        wdata_d = store_data;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = load_data;
                    end
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    rd_d   = 1'b1;
                    addr_d = lat_q.addr;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they belong to; async reset drops mem_write mid-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= ZERO32;
            wdata_q <= ZERO32;
            rdata_q <= ZERO32;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: no reset on the latched request: it is written on every accept
    // before any state that reads it is entered.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.req) begin
            lat_q <= '{we:    bus.req_we,
                       size:  req_size_e,
                       sgn:   bus.req_signed,
                       addr:  bus.req_addr,
                       wdata: bus.req_wdata};
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_read   = rd_q;
    assign bus.mem_write  = wr_q;
    assign bus.address    = addr_q;
    assign bus.write_data = wdata_q;

endmodule
